// File: rtl/audio_stream_framer.sv
// Streams NUM_SAMPLES SD-card samples through a show-ahead FIFO to the MFCC front end,
// tagging frame boundaries every FRAME_LEN samples; runs restart on a start pulse.
module audio_stream_framer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_SAMPLES = 1024,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned FRAME_LEN   = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              sd_read_req,
  input  logic              sd_data_valid,
  input  logic [DATA_W-1:0] sd_data,
  output logic [DATA_W-1:0] mfcc_data,
  output logic              mfcc_data_valid,
  input  logic              mfcc_data_ready,
  output logic              mfcc_frame_start,
  output logic              mfcc_frame_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sample_count
);

  localparam int unsigned      PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] NUM_C   = CNT_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] FLAST_C = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic               outst_q, outst_d;
  logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               fstart_q, fstart_d;
  logic               flast_q, flast_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];

  logic launch;
  logic push;
  logic pop;
  logic issue;

  assign launch = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  // Only the sample answering our single outstanding request is accepted.
  assign push   = outst_q && sd_data_valid;
  assign pop    = valid_q && mfcc_data_ready;
  assign issue  = (state_q == S_RUN) && !outst_q && (req_cnt_q < NUM_C) && (cnt_q < DEPTH_C);

  // Next-state, counters and registered output decode.
  always_comb begin
    state_d   = state_q;
    req_d     = 1'b0;
    outst_d   = outst_q;
    req_cnt_d = req_cnt_q;
    sent_d    = sent_q;
    idx_d     = idx_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if ((req_cnt_q == NUM_C) && !outst_q) state_d = S_DRAIN;
      S_DRAIN: if (sent_q == NUM_C) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      outst_d  = 1'b0;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      sent_d   = sent_q + CNT_W'(1);
      idx_d    = (idx_q == FLAST_C) ? '0 : idx_q + CNT_W'(1);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    if (issue) begin
      req_d     = 1'b1;
      outst_d   = 1'b1;
      req_cnt_d = req_cnt_q + CNT_W'(1);
    end

    // A launch restarts the run and fires the first request on the same edge.
    if (launch) begin
      state_d   = S_RUN;
      req_d     = 1'b1;
      outst_d   = 1'b1;
      req_cnt_d = CNT_W'(1);
      sent_d    = '0;
      idx_d     = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
    end

    busy_d   = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d   = (state_d == S_DONE);
    valid_d  = busy_d && (cnt_d != '0);
    fstart_d = valid_d && (idx_d == '0);
    flast_d  = valid_d && ((idx_d == FLAST_C) || (sent_d == LAST_C));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      outst_q   <= 1'b0;
      req_cnt_q <= '0;
      sent_q    <= '0;
      idx_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      fstart_q  <= 1'b0;
      flast_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      outst_q   <= outst_d;
      req_cnt_q <= req_cnt_d;
      sent_q    <= sent_d;
      idx_q     <= idx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      fstart_q  <= fstart_d;
      flast_q   <= flast_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Storage is cleared on reset so the head output reads zero until refilled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (push) begin
      mem_q[wr_ptr_q] <= sd_data;
    end
  end

  assign sd_read_req      = req_q;
  assign mfcc_data        = mem_q[rd_ptr_q];
  assign mfcc_data_valid  = valid_q;
  assign mfcc_frame_start = fstart_q;
  assign mfcc_frame_last  = flast_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign sample_count     = sent_q;

endmodule

// File: tb/tb_audio_stream_framer.sv
// Randomised bench for audio_stream_framer: an SD responder with random latency feeds the
// DUT and the delivered stream is compared with the data returned, in order, plus frame tags.
module tb_audio_stream_framer;

  localparam int unsigned DW = 8;
  localparam int unsigned NS = 10;
  localparam int unsigned FD = 4;
  localparam int unsigned FL = 4;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sd_read_req;
  logic          sd_data_valid;
  logic [DW-1:0] sd_data;
  logic [DW-1:0] mfcc_data;
  logic          mfcc_data_valid;
  logic          mfcc_data_ready;
  logic          mfcc_frame_start;
  logic          mfcc_frame_last;
  logic          busy;
  logic          done;
  logic [CW-1:0] sample_count;

  always #5 clk = ~clk;

  audio_stream_framer #(
    .DATA_W(DW), .NUM_SAMPLES(NS), .FIFO_DEPTH(FD), .FRAME_LEN(FL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .sd_read_req(sd_read_req), .sd_data_valid(sd_data_valid), .sd_data(sd_data),
    .mfcc_data(mfcc_data), .mfcc_data_valid(mfcc_data_valid), .mfcc_data_ready(mfcc_data_ready),
    .mfcc_frame_start(mfcc_frame_start), .mfcc_frame_last(mfcc_frame_last),
    .busy(busy), .done(done), .sample_count(sample_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit sd_auto    = 1'b1;
  bit stray_en   = 1'b0;
  bit rand_ready = 1'b0;
  bit pend       = 1'b0;
  int wait_n     = 0;
  int req_seen   = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_d [$];
  bit            got_s [$];
  bit            got_l [$];

  function automatic bit exp_start(int k);
    return (k % FL) == 0;
  endfunction

  function automatic bit exp_last(int k);
    return ((k % FL) == FL - 1) || (k == NS - 1);
  endfunction

  // One clock: capture a transfer, then play the SD side and the ready pattern.
  task automatic tick();
    logic [DW-1:0] v;
    if (mfcc_data_valid && mfcc_data_ready) begin
      got_d.push_back(mfcc_data);
      got_s.push_back(mfcc_frame_start);
      got_l.push_back(mfcc_frame_last);
    end
    @(posedge clk);
    #1;
    sd_data_valid = 1'b0;
    if (sd_auto) begin
      if (pend) begin
        if (wait_n == 0) begin
          v = DW'($urandom_range(0, 255));
          if (v == 8'hAA) v = 8'h55;
          sd_data       = v;
          sd_data_valid = 1'b1;
          exp_q.push_back(v);
          pend = 1'b0;
        end else begin
          wait_n--;
        end
      end
      if (sd_read_req) begin
        req_seen++;
        pend   = 1'b1;
        wait_n = int'($urandom_range(0, 2));
      end
      if (stray_en && !pend && !sd_data_valid && ($urandom_range(0, 2) == 0)) begin
        sd_data       = 8'hAA;
        sd_data_valid = 1'b1;
      end
    end
    if (rand_ready) mfcc_data_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic clear_run();
    exp_q.delete();
    got_d.delete();
    got_s.delete();
    got_l.delete();
    req_seen = 0;
    pend     = 1'b0;
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(string name);
    for (int c = 0; c < 2000 && !done; c++) tick();
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_timeout: done=%b after budget, required 1", name, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sd_data_valid = 1'b0; sd_data = '0; mfcc_data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({sd_read_req, mfcc_data_valid, mfcc_data, mfcc_frame_start, mfcc_frame_last, busy, done, sample_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: req=%b v=%b d=%h fs=%b fl=%b busy=%b done=%b cnt=%0d, required all 0",
               sd_read_req, mfcc_data_valid, mfcc_data, mfcc_frame_start, mfcc_frame_last, busy, done, sample_count);
    end
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({sd_read_req, busy, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_idle_hold: req/busy/done=%b%b%b, required 000", sd_read_req, busy, done);
    end
  endtask

  task automatic test_basic();
    clear_run();
    rand_ready = 1'b0; mfcc_data_ready = 1'b1;
    launch();
    n_cmp++;
    if ({sd_read_req, busy, done, sample_count} !== {1'b1, 1'b1, 1'b0, CW'(0)}) begin
      n_bad++;
      $display("FAIL basic_launch: req=%b busy=%b done=%b cnt=%0d, required 1 1 0 0", sd_read_req, busy, done, sample_count);
    end
    run_to_done("basic");
    n_cmp++;
    if (got_d.size() != NS) begin
      n_bad++;
      $display("FAIL basic_len: got %0d samples, required %0d", got_d.size(), NS);
    end
    for (int k = 0; k < got_d.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if ({got_d[k], got_s[k], got_l[k]} !== {exp_q[k], exp_start(k), exp_last(k)}) begin
        n_bad++;
        $display("FAIL basic_seq[%0d]: d=%h fs=%b fl=%b, required d=%h fs=%b fl=%b",
                 k, got_d[k], got_s[k], got_l[k], exp_q[k], exp_start(k), exp_last(k));
      end
    end
    n_cmp++;
    if ({sample_count, busy, mfcc_data_valid, req_seen} !== {CW'(NS), 1'b0, 1'b0, 32'(NS)}) begin
      n_bad++;
      $display("FAIL basic_end: cnt=%0d busy=%b v=%b reqs=%0d, required %0d 0 0 %0d",
               sample_count, busy, mfcc_data_valid, req_seen, NS, NS);
    end
  endtask

  task automatic test_back_pressure();
    logic [DW+1:0] ref_v;
    bit            have;
    have = 1'b0;
    ref_v = '0;
    clear_run();
    rand_ready = 1'b0; mfcc_data_ready = 1'b0;
    launch();
    repeat (20) begin
      tick();
      if (have) begin
        n_cmp++;
        if ({mfcc_data_valid, mfcc_data, mfcc_frame_start, mfcc_frame_last} !== {1'b1, ref_v}) begin
          n_bad++;
          $display("FAIL bp_hold: v=%b d=%h fs=%b fl=%b, required v=1 {d,fs,fl}=%h",
                   mfcc_data_valid, mfcc_data, mfcc_frame_start, mfcc_frame_last, ref_v);
        end
      end else if (mfcc_data_valid) begin
        have  = 1'b1;
        ref_v = {mfcc_data, mfcc_frame_start, mfcc_frame_last};
      end
    end
    n_cmp++;
    if ({req_seen, sd_read_req, got_d.size()} !== {32'(FD), 1'b0, 32'(0)}) begin
      n_bad++;
      $display("FAIL bp_stall: reqs=%0d req=%b delivered=%0d, required %0d 0 0", req_seen, sd_read_req, got_d.size(), FD);
    end
    mfcc_data_ready = 1'b1;
    run_to_done("bp");
    n_cmp++;
    if (got_d.size() != NS) begin
      n_bad++;
      $display("FAIL bp_len: got %0d samples, required %0d", got_d.size(), NS);
    end
    for (int k = 0; k < got_d.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if ({got_d[k], got_s[k], got_l[k]} !== {exp_q[k], exp_start(k), exp_last(k)}) begin
        n_bad++;
        $display("FAIL bp_seq[%0d]: d=%h fs=%b fl=%b, required d=%h fs=%b fl=%b",
                 k, got_d[k], got_s[k], got_l[k], exp_q[k], exp_start(k), exp_last(k));
      end
    end
  endtask

  task automatic test_random_ready();
    clear_run();
    rand_ready = 1'b1;
    launch();
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done("rand");
    rand_ready = 1'b0;
    n_cmp++;
    if ({got_d.size(), req_seen, sample_count} !== {32'(NS), 32'(NS), CW'(NS)}) begin
      n_bad++;
      $display("FAIL rand_len: delivered=%0d reqs=%0d cnt=%0d, required %0d each", got_d.size(), req_seen, sample_count, NS);
    end
    for (int k = 0; k < got_d.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if ({got_d[k], got_s[k], got_l[k]} !== {exp_q[k], exp_start(k), exp_last(k)}) begin
        n_bad++;
        $display("FAIL rand_seq[%0d]: d=%h fs=%b fl=%b, required d=%h fs=%b fl=%b",
                 k, got_d[k], got_s[k], got_l[k], exp_q[k], exp_start(k), exp_last(k));
      end
    end
  endtask

  task automatic test_stray();
    clear_run();
    stray_en = 1'b1; rand_ready = 1'b1;
    launch();
    run_to_done("stray");
    stray_en = 1'b0; rand_ready = 1'b0; mfcc_data_ready = 1'b1;
    n_cmp++;
    if (got_d.size() != NS) begin
      n_bad++;
      $display("FAIL stray_len: got %0d samples, required %0d", got_d.size(), NS);
    end
    for (int k = 0; k < got_d.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if ({got_d[k], got_s[k], got_l[k]} !== {exp_q[k], exp_start(k), exp_last(k)}) begin
        n_bad++;
        $display("FAIL stray_seq[%0d]: d=%h fs=%b fl=%b, required d=%h fs=%b fl=%b",
                 k, got_d[k], got_s[k], got_l[k], exp_q[k], exp_start(k), exp_last(k));
      end
    end
  endtask

  task automatic test_restart_from_done();
    repeat (3) tick();
    n_cmp++;
    if ({done, busy, mfcc_data_valid, sd_read_req} !== 4'b1000) begin
      n_bad++;
      $display("FAIL done_hold: done/busy/v/req=%b%b%b%b, required 1000", done, busy, mfcc_data_valid, sd_read_req);
    end
    clear_run();
    mfcc_data_ready = 1'b1;
    launch();
    n_cmp++;
    if ({done, busy, sample_count, sd_read_req} !== {1'b0, 1'b1, CW'(0), 1'b1}) begin
      n_bad++;
      $display("FAIL restart: done=%b busy=%b cnt=%0d req=%b, required 0 1 0 1", done, busy, sample_count, sd_read_req);
    end
    run_to_done("restart");
    n_cmp++;
    if (got_d.size() != NS) begin
      n_bad++;
      $display("FAIL restart_len: got %0d samples, required %0d", got_d.size(), NS);
    end
    for (int k = 0; k < got_d.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if ({got_d[k], got_s[k], got_l[k]} !== {exp_q[k], exp_start(k), exp_last(k)}) begin
        n_bad++;
        $display("FAIL restart_seq[%0d]: d=%h fs=%b fl=%b, required d=%h fs=%b fl=%b",
                 k, got_d[k], got_s[k], got_l[k], exp_q[k], exp_start(k), exp_last(k));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int c;
    clear_run();
    mfcc_data_ready = 1'b1;
    launch();
    c = 0;
    while (!(got_d.size() >= 3 && pend) && c < 500) begin
      tick();
      c++;
    end
    n_cmp++;
    if (!(got_d.size() >= 3 && pend)) begin
      n_bad++;
      $display("FAIL mid_setup: delivered=%0d pending=%b, required >=3 and 1", got_d.size(), pend);
    end
    sd_auto = 1'b0;
    pend    = 1'b0;
    rst     = 1'b1;
    #1;
    n_cmp++;
    if ({sd_read_req, mfcc_data_valid, mfcc_data, mfcc_frame_start, mfcc_frame_last, busy, done, sample_count} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: req=%b v=%b d=%h fs=%b fl=%b busy=%b done=%b cnt=%0d, required all 0",
               sd_read_req, mfcc_data_valid, mfcc_data, mfcc_frame_start, mfcc_frame_last, busy, done, sample_count);
    end
    tick();
    rst = 1'b0;
    tick();
    sd_data       = 8'h33;
    sd_data_valid = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++;
    if ({mfcc_data_valid, busy, done, sd_read_req, sample_count} !== {4'b0000, CW'(0)}) begin
      n_bad++;
      $display("FAIL mid_late_data: v=%b busy=%b done=%b req=%b cnt=%0d, required all 0",
               mfcc_data_valid, busy, done, sd_read_req, sample_count);
    end
    sd_auto = 1'b1;
    clear_run();
    launch();
    run_to_done("mid_rerun");
    n_cmp++;
    if (got_d.size() != NS) begin
      n_bad++;
      $display("FAIL mid_rerun_len: got %0d samples, required %0d", got_d.size(), NS);
    end
    for (int k = 0; k < got_d.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if ({got_d[k], got_s[k], got_l[k]} !== {exp_q[k], exp_start(k), exp_last(k)}) begin
        n_bad++;
        $display("FAIL mid_rerun_seq[%0d]: d=%h fs=%b fl=%b, required d=%h fs=%b fl=%b",
                 k, got_d[k], got_s[k], got_l[k], exp_q[k], exp_start(k), exp_last(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_random_ready();
    test_stray();
    test_restart_from_done();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
